// File: rtl/signal_run_sequencer.sv
`timescale 1ns/1ps
// signal_run_sequencer: staging register file, shadow parameter outputs and
// the run-control FSM that launches frame runs on txdone and counts them.
module signal_run_sequencer #(
  parameter int          TX_HOLD = 8,
  parameter int unsigned TIMEOUT = 32'd400_000_000
) (
  input  logic        sys_clk_100M,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        cfg_rd,
  output logic [7:0]  cfg_rdata,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        frame_done,
  output logic        txdone,
  output logic        busy,
  output logic        run_done,
  output logic        err_timeout,
  output logic [15:0] runs_completed,
  output logic [63:0] frame_period,
  output logic [31:0] pixel_period,
  output logic [31:0] laser_period,
  output logic [31:0] spad_period,
  output logic [31:0] sig_start_frame,
  output logic [31:0] sig_start_pixel,
  output logic [31:0] sig_start_laser,
  output logic [31:0] sig_start_spad,
  output logic [15:0] duty_cycle_frame,
  output logic [15:0] duty_cycle_pixel,
  output logic [15:0] duty_cycle_laser,
  output logic [15:0] duty_cycle_spad,
  output logic [7:0]  frame_nums,
  output logic [7:0]  pixel_nums,
  output logic [7:0]  laser_nums,
  output logic [7:0]  spad_nums,
  output logic [8:0]  i_cnt_value
);

  // Bytes 0x00..0x34 are backed by storage; 0x00..0x2F form the wide fields.
  localparam int STAGE_BYTES = 53;
  localparam int FLAT_BYTES  = 48;
  localparam int ADDR_ICNT_HI = 49;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_RUN, S_GAP} state_t;

  state_t      state_reg;
  logic [7:0]  stage_reg [0:STAGE_BYTES-1];
  logic [8*FLAT_BYTES-1:0] stage_flat;
  logic [7:0]  remaining_reg;
  logic [7:0]  hold_cnt_reg;
  logic [15:0] gap_cnt_reg;
  logic [31:0] timeout_cnt_reg;
  logic        stop_pending_reg;
  logic        fd_s1_reg, fd_s2_reg, fd_s3_reg, fd_rise_reg;
  logic [15:0] gap_cycles;
  logic [7:0]  run_count;

  genvar gi;

  // Little-endian flat view of the wide-field bytes for easy slicing.
  generate
    for (gi = 0; gi < FLAT_BYTES; gi++) begin : g_flat
      assign stage_flat[8*gi +: 8] = stage_reg[gi];
    end
  endgenerate

  assign run_count  = stage_reg[50];
  assign gap_cycles = {stage_reg[52], stage_reg[51]};

  // Staging writes land in any state; i_cnt_value high byte keeps only bit 0.
  always_ff @(posedge sys_clk_100M or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGE_BYTES; i++) stage_reg[i] <= 8'd0;
    end else begin
      for (int i = 0; i < STAGE_BYTES; i++) begin
        if (cfg_wr && cfg_addr == 6'(i)) begin
          if (i == ADDR_ICNT_HI) stage_reg[i] <= {7'd0, cfg_wdata[0]};
          else                   stage_reg[i] <= cfg_wdata;
        end
      end
    end
  end

  // Registered readback; a same-cycle write is not yet visible, unmapped reads 0.
  always_ff @(posedge sys_clk_100M or negedge reset) begin
    if (!reset) begin
      cfg_rdata <= 8'd0;
    end else if (cfg_rd) begin
      cfg_rdata <= (cfg_addr < 6'(STAGE_BYTES)) ? stage_reg[cfg_addr] : 8'd0;
    end
  end

  // Two-flop synchronizer for the 400 MHz frame_done plus a registered rise pulse.
  always_ff @(posedge sys_clk_100M or negedge reset) begin
    if (!reset) begin
      fd_s1_reg   <= 1'b0;
      fd_s2_reg   <= 1'b0;
      fd_s3_reg   <= 1'b0;
      fd_rise_reg <= 1'b0;
    end else begin
      fd_s1_reg   <= frame_done;
      fd_s2_reg   <= fd_s1_reg;
      fd_s3_reg   <= fd_s2_reg;
      fd_rise_reg <= fd_s2_reg & ~fd_s3_reg;
    end
  end

  // Shadows copy the whole staging file at once, only while in LOAD.
  always_ff @(posedge sys_clk_100M or negedge reset) begin
    if (!reset) begin
      frame_period     <= 64'd0;
      pixel_period     <= 32'd0;
      laser_period     <= 32'd0;
      spad_period      <= 32'd0;
      sig_start_frame  <= 32'd0;
      sig_start_pixel  <= 32'd0;
      sig_start_laser  <= 32'd0;
      sig_start_spad   <= 32'd0;
      duty_cycle_frame <= 16'd0;
      duty_cycle_pixel <= 16'd0;
      duty_cycle_laser <= 16'd0;
      duty_cycle_spad  <= 16'd0;
      frame_nums       <= 8'd0;
      pixel_nums       <= 8'd0;
      laser_nums       <= 8'd0;
      spad_nums        <= 8'd0;
      i_cnt_value      <= 9'd0;
    end else if (state_reg == S_LOAD) begin
      frame_period     <= stage_flat[8*8'h00 +: 64];
      pixel_period     <= stage_flat[8*8'h08 +: 32];
      laser_period     <= stage_flat[8*8'h0C +: 32];
      spad_period      <= stage_flat[8*8'h10 +: 32];
      sig_start_frame  <= stage_flat[8*8'h14 +: 32];
      sig_start_pixel  <= stage_flat[8*8'h18 +: 32];
      sig_start_laser  <= stage_flat[8*8'h1C +: 32];
      sig_start_spad   <= stage_flat[8*8'h20 +: 32];
      duty_cycle_frame <= stage_flat[8*8'h24 +: 16];
      duty_cycle_pixel <= stage_flat[8*8'h26 +: 16];
      duty_cycle_laser <= stage_flat[8*8'h28 +: 16];
      duty_cycle_spad  <= stage_flat[8*8'h2A +: 16];
      frame_nums       <= stage_flat[8*8'h2C +: 8];
      pixel_nums       <= stage_flat[8*8'h2D +: 8];
      laser_nums       <= stage_flat[8*8'h2E +: 8];
      spad_nums        <= stage_flat[8*8'h2F +: 8];
      i_cnt_value      <= {stage_reg[ADDR_ICNT_HI][0], stage_reg[48]};
    end
  end

  // Run-control FSM; remaining==0 means continuous mode for the whole session.
  always_ff @(posedge sys_clk_100M or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      txdone           <= 1'b0;
      busy             <= 1'b0;
      run_done         <= 1'b0;
      err_timeout      <= 1'b0;
      runs_completed   <= 16'd0;
      stop_pending_reg <= 1'b0;
      remaining_reg    <= 8'd0;
      hold_cnt_reg     <= 8'd0;
      gap_cnt_reg      <= 16'd0;
      timeout_cnt_reg  <= 32'd0;
    end else begin
      run_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          stop_pending_reg <= 1'b0;
          if (cmd_start && !cmd_stop) begin
            state_reg      <= S_LOAD;
            busy           <= 1'b1;
            err_timeout    <= 1'b0;
            runs_completed <= 16'd0;
            remaining_reg  <= run_count;
          end
        end
        S_LOAD: begin
          // A stop here is remembered so the launch that follows is the last.
          if (cmd_stop) stop_pending_reg <= 1'b1;
          state_reg    <= S_FIRE;
          txdone       <= 1'b1;
          hold_cnt_reg <= 8'(TX_HOLD - 1);
        end
        S_FIRE: begin
          if (cmd_stop) stop_pending_reg <= 1'b1;
          if (hold_cnt_reg == 8'd0) begin
            txdone          <= 1'b0;
            state_reg       <= S_RUN;
            timeout_cnt_reg <= 32'd0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 8'd1;
          end
        end
        S_RUN: begin
          if (cmd_stop) stop_pending_reg <= 1'b1;
          if (fd_rise_reg) begin
            if (runs_completed != 16'hFFFF) runs_completed <= runs_completed + 16'd1;
            if (stop_pending_reg || cmd_stop || remaining_reg == 8'd1) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
              run_done  <= 1'b1;
            end else begin
              if (remaining_reg != 8'd0) remaining_reg <= remaining_reg - 8'd1;
              state_reg   <= S_GAP;
              gap_cnt_reg <= (gap_cycles == 16'd0) ? 16'd0 : gap_cycles - 16'd1;
            end
          end else if (TIMEOUT != 0 && timeout_cnt_reg == TIMEOUT - 32'd1) begin
            state_reg   <= S_IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
          end
        end
        S_GAP: begin
          if (cmd_stop) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            run_done  <= 1'b1;
          end else if (gap_cnt_reg == 16'd0) begin
            state_reg <= S_LOAD;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 16'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          txdone    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_run_sequencer.sv
`timescale 1ns/1ps
// Directed bench for signal_run_sequencer: register file, launch timing,
// multi-run sequencing, stop, timeout and reset behaviour.
module tb_signal_run_sequencer;

  logic        sys_clk_100M = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [5:0]  cfg_addr = 6'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        cfg_rd = 1'b0;
  logic [7:0]  cfg_rdata;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        frame_done = 1'b0;
  logic        txdone, busy, run_done, err_timeout;
  logic [15:0] runs_completed;
  logic [63:0] frame_period;
  logic [31:0] pixel_period, laser_period, spad_period;
  logic [31:0] sig_start_frame, sig_start_pixel, sig_start_laser, sig_start_spad;
  logic [15:0] duty_cycle_frame, duty_cycle_pixel, duty_cycle_laser, duty_cycle_spad;
  logic [7:0]  frame_nums, pixel_nums, laser_nums, spad_nums;
  logic [8:0]  i_cnt_value;

  int n_checks = 0;
  int n_fail   = 0;

  signal_run_sequencer #(.TX_HOLD(8), .TIMEOUT(32'd1000)) dut (
    .sys_clk_100M(sys_clk_100M), .reset(reset),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rd(cfg_rd), .cfg_rdata(cfg_rdata),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .frame_done(frame_done),
    .txdone(txdone), .busy(busy), .run_done(run_done), .err_timeout(err_timeout),
    .runs_completed(runs_completed),
    .frame_period(frame_period), .pixel_period(pixel_period),
    .laser_period(laser_period), .spad_period(spad_period),
    .sig_start_frame(sig_start_frame), .sig_start_pixel(sig_start_pixel),
    .sig_start_laser(sig_start_laser), .sig_start_spad(sig_start_spad),
    .duty_cycle_frame(duty_cycle_frame), .duty_cycle_pixel(duty_cycle_pixel),
    .duty_cycle_laser(duty_cycle_laser), .duty_cycle_spad(duty_cycle_spad),
    .frame_nums(frame_nums), .pixel_nums(pixel_nums),
    .laser_nums(laser_nums), .spad_nums(spad_nums),
    .i_cnt_value(i_cnt_value)
  );

  always #5 sys_clk_100M = ~sys_clk_100M;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_100M);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    cfg_addr = a; cfg_rd = 1'b1;
    tick();
    cfg_rd = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  // Number of consecutive observed cycles with txdone high, starting now.
  task automatic measure_high(output int n);
    n = 0;
    while (txdone === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  // Raise frame_done (dropped after 3 cycles) and watch for run_done / next launch.
  task automatic frame_and_wait(output int n_rise, output int n_done, output int pulses);
    n_rise = -1; n_done = -1; pulses = 0;
    frame_done = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 3) frame_done = 1'b0;
      if (run_done === 1'b1) begin
        pulses++;
        if (n_done < 0) n_done = c;
      end
      if (txdone === 1'b1) begin
        n_rise = c;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int n, nr, nd, np, saw_done;

    // Reset
    repeat (3) tick();
    reset = 1'b1;
    tick();
    expect_eq("rst_txdone", txdone, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_run_done", run_done, 0);
    expect_eq("rst_err_timeout", err_timeout, 0);
    expect_eq("rst_runs_completed", runs_completed, 0);
    expect_eq("rst_frame_period", frame_period, 0);
    expect_eq("rst_pixel_period", pixel_period, 0);
    expect_eq("rst_sig_start_spad", sig_start_spad, 0);
    expect_eq("rst_duty_cycle_spad", duty_cycle_spad, 0);
    expect_eq("rst_spad_nums", spad_nums, 0);
    expect_eq("rst_i_cnt_value", i_cnt_value, 0);
    for (int a = 0; a <= 8'h34; a++) begin
      rd(6'(a), d);
      expect_eq($sformatf("rst_read_%02h", a), d, 0);
    end

    // Register file: same-cycle read/write returns old data, unmapped reads 0
    cfg_addr = 6'h08; cfg_wdata = 8'h78; cfg_wr = 1'b1; cfg_rd = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    expect_eq("rdwr_same_cycle_old", cfg_rdata, 8'h00);
    rd(6'h08, d);
    expect_eq("read_after_write_08", d, 8'h78);
    wr(6'h09, 8'h56); wr(6'h0A, 8'h34); wr(6'h0B, 8'h12);
    wr(6'h32, 8'd1); wr(6'h33, 8'd0); wr(6'h34, 8'd0);
    rd(6'h0B, d);
    expect_eq("read_0b", d, 8'h12);
    wr(6'h35, 8'hAA);
    rd(6'h35, d);
    expect_eq("read_unmapped_35", d, 8'h00);
    rd(6'h3F, d);
    expect_eq("read_unmapped_3f", d, 8'h00);

    // start together with stop is ignored
    cmd_start = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    expect_eq("start_with_stop_busy", busy, 0);

    // Single run
    start();
    expect_eq("r1_busy_n1", busy, 1);
    expect_eq("r1_txdone_n1", txdone, 0);
    expect_eq("r1_pixel_n1_old", pixel_period, 0);
    tick();
    expect_eq("r1_txdone_n2", txdone, 1);
    expect_eq("r1_pixel_n2", pixel_period, 32'h12345678);
    measure_high(n);
    expect_eq("r1_tx_hold", n, 8);
    frame_and_wait(nr, nd, np);
    expect_eq("r1_no_relaunch", nr, -1);
    expect_eq("r1_run_done_lat", nd, 4);
    expect_eq("r1_run_done_pulses", np, 1);
    expect_eq("r1_runs_completed", runs_completed, 1);
    expect_eq("r1_busy_end", busy, 0);

    // Three runs with gap 10; staging write in run 2 shows at launch 3
    wr(6'h32, 8'd3); wr(6'h33, 8'd10);
    start();
    expect_eq("r3_runs_cleared", runs_completed, 0);
    tick();
    measure_high(n);
    expect_eq("r3_l1_hold", n, 8);
    frame_and_wait(nr, nd, np);
    expect_eq("r3_l2_spacing", nr, 15);
    expect_eq("r3_l2_runs", runs_completed, 1);
    expect_eq("r3_l2_pixel", pixel_period, 32'h12345678);
    measure_high(n);
    expect_eq("r3_l2_hold", n, 8);
    wr(6'h08, 8'h11);
    expect_eq("r3_pixel_unchanged_in_run", pixel_period, 32'h12345678);
    frame_and_wait(nr, nd, np);
    expect_eq("r3_l3_spacing", nr, 15);
    expect_eq("r3_l3_runs", runs_completed, 2);
    expect_eq("r3_l3_pixel", pixel_period, 32'h12345611);
    measure_high(n);
    frame_and_wait(nr, nd, np);
    expect_eq("r3_no_4th_launch", nr, -1);
    expect_eq("r3_run_done_lat", nd, 4);
    expect_eq("r3_run_done_pulses", np, 1);
    expect_eq("r3_runs_completed", runs_completed, 3);

    // Continuous mode, gap 0; stop in run 4 lets it finish
    wr(6'h32, 8'd0); wr(6'h33, 8'd0);
    start();
    tick();
    measure_high(n);
    for (int i = 1; i <= 3; i++) begin
      frame_and_wait(nr, nd, np);
      expect_eq($sformatf("cont_l%0d_spacing", i + 1), nr, 6);
      expect_eq($sformatf("cont_l%0d_runs", i + 1), runs_completed, i);
      measure_high(n);
    end
    stop();
    frame_and_wait(nr, nd, np);
    expect_eq("cont_no_5th_launch", nr, -1);
    expect_eq("cont_run_done_lat", nd, 4);
    expect_eq("cont_run_done_pulses", np, 1);
    expect_eq("cont_runs_completed", runs_completed, 4);

    // Stop during GAP ends immediately
    wr(6'h33, 8'd20);
    start();
    tick();
    measure_high(n);
    frame_done = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 3) frame_done = 1'b0;
    end
    expect_eq("gap_busy_before_stop", busy, 1);
    stop();
    expect_eq("gap_stop_busy", busy, 0);
    expect_eq("gap_stop_run_done", run_done, 1);
    expect_eq("gap_stop_runs", runs_completed, 1);
    tick();
    expect_eq("gap_stop_run_done_once", run_done, 0);

    // Timeout with frame_done withheld
    start();
    tick();
    measure_high(n);
    n = 0; saw_done = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
      if (run_done === 1'b1) saw_done = 1;
    end
    expect_eq("to_run_cycles", n, 1000);
    expect_eq("to_err_timeout", err_timeout, 1);
    expect_eq("to_no_run_done", saw_done, 0);
    start();
    expect_eq("to_err_cleared", err_timeout, 0);
    tick();
    tick();
    expect_eq("rst_fire_txdone_high", txdone, 1);

    // Reset in FIRE
    reset = 1'b0;
    #2;
    expect_eq("rst_fire_txdone", txdone, 0);
    expect_eq("rst_fire_busy", busy, 0);
    expect_eq("rst_fire_pixel", pixel_period, 0);
    tick();
    reset = 1'b1;
    tick();

    // i_cnt_value width masking
    wr(6'h30, 8'hFF); wr(6'h31, 8'hFF);
    rd(6'h31, d);
    expect_eq("icnt_read_31", d, 8'h01);
    rd(6'h30, d);
    expect_eq("icnt_read_30", d, 8'hFF);
    expect_eq("icnt_before_load", i_cnt_value, 0);
    start();
    tick();
    expect_eq("icnt_after_load", i_cnt_value, 9'h1FF);
    stop();
    measure_high(n);
    frame_and_wait(nr, nd, np);
    expect_eq("icnt_stop_run_done", nd, 4);
    expect_eq("icnt_stop_no_relaunch", nr, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
